// File: rtl/data_mem_responder_pkg.sv
// Shared register map for data_mem_responder: MMIO offsets, STATUS bit indices and write-permission decode.
// The timer offsets count as writable only when DMR_TIMER_EN is defined.
package data_mem_responder_pkg;

    localparam logic [2:0] OFF_GPIO_OUT   = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN    = 3'd1;
    localparam logic [2:0] OFF_STATUS     = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN     = 3'd3;
    localparam logic [2:0] OFF_TMR_CTRL   = 3'd4;
    localparam logic [2:0] OFF_TMR_CNT    = 3'd5;
    localparam logic [2:0] OFF_TMR_RELOAD = 3'd6;

    localparam int STAT_WR_FAULT = 0;
    localparam int STAT_TMR_OVF  = 1;

    function automatic logic reg_writable(input logic [2:0] off);
        case (off)
            OFF_GPIO_OUT, OFF_STATUS, OFF_IRQ_EN: return 1'b1;
`ifdef DMR_TIMER_EN
            OFF_TMR_CTRL, OFF_TMR_RELOAD:        return 1'b1;
`endif
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmr_timer.sv
// Free-running up-counter for data_mem_responder; reloads and pulses ovf_pulse when it wraps past all-ones.
// Only compiled when DMR_TIMER_EN is defined.
`ifdef DMR_TIMER_EN
module dmr_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic [WIDTH-1:0] reload,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf_pulse
);

    // Pulse is combinational so STATUS captures it on the same edge the reload lands.
    assign ovf_pulse = en && (cnt == '1);

    always_ff @(posedge clk) begin
        if (arst) begin
            cnt <= '0;
        end else if (ovf_pulse) begin
            cnt <= reload;
        end else if (en) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule
`endif

// File: rtl/data_mem_responder.sv
// Zero-wait-state data memory with GPIO, sticky STATUS/IRQ and an optional timer in the top MMIO block.
// Define DMR_TIMER_EN to build the timer; otherwise offsets +4..+6 are reserved.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 8'hF8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_WE,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] ram [0:int'(MMIO_BASE)-1];

    logic                  is_ram;
    logic [ADDR_WIDTH-1:0] off_full;
    logic                  reg_hit;
    logic [2:0]            off;
    logic                  wr_reg;
    logic                  bad_wr;

    logic [DATA_WIDTH-1:0] gpio_meta;
    logic [DATA_WIDTH-1:0] gpio_sync;
    logic [1:0]            status;
    logic [1:0]            status_set;
    logic [1:0]            status_clr;
    logic [1:0]            irq_en;

    logic                  tmr_en;
    logic [DATA_WIDTH-1:0] tmr_reload;
    logic [DATA_WIDTH-1:0] tmr_cnt;
    logic                  tmr_ovf;

    assign is_ram   = (mem_addr < MMIO_BASE);
    assign off_full = mem_addr - MMIO_BASE;
    assign reg_hit  = !is_ram && ((off_full >> 3) == '0);
    assign off      = off_full[2:0];
    assign wr_reg   = mem_WE && reg_hit;
    // Anything in the MMIO window that is not a writable register is a faulting write.
    assign bad_wr   = mem_WE && !is_ram && !(reg_hit && reg_writable(off));

    always_ff @(posedge clk) begin
        if (!arst && mem_WE && is_ram) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = '0;
        if (is_ram) begin
            mem_rdata = ram[mem_addr];
        end else if (reg_hit) begin
            case (off)
                OFF_GPIO_OUT:   mem_rdata = gpio_out;
                OFF_GPIO_IN:    mem_rdata = gpio_sync;
                OFF_STATUS:     mem_rdata = {{(DATA_WIDTH-2){1'b0}}, status};
                OFF_IRQ_EN:     mem_rdata = {{(DATA_WIDTH-2){1'b0}}, irq_en};
                OFF_TMR_CTRL:   mem_rdata = {{(DATA_WIDTH-1){1'b0}}, tmr_en};
                OFF_TMR_CNT:    mem_rdata = tmr_cnt;
                OFF_TMR_RELOAD: mem_rdata = tmr_reload;
                default:        mem_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            gpio_meta <= '0;
            gpio_sync <= '0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            gpio_out <= '0;
            irq_en   <= '0;
        end else begin
            if (wr_reg && off == OFF_GPIO_OUT) gpio_out <= mem_wdata;
            if (wr_reg && off == OFF_IRQ_EN)   irq_en   <= mem_wdata[1:0];
        end
    end

    always_comb begin
        status_set                = '0;
        status_set[STAT_WR_FAULT] = bad_wr;
        status_set[STAT_TMR_OVF]  = tmr_ovf;
        status_clr                = '0;
        if (wr_reg && off == OFF_STATUS) status_clr = mem_wdata[1:0];
    end

    // Set is OR-ed in after the clear so a simultaneous hardware event wins.
    always_ff @(posedge clk) begin
        if (arst) begin
            status <= '0;
            irq    <= 1'b0;
        end else begin
            status <= (status & ~status_clr) | status_set;
            irq    <= |(status & irq_en);
        end
    end

`ifdef DMR_TIMER_EN
    always_ff @(posedge clk) begin
        if (arst) begin
            tmr_en     <= 1'b0;
            tmr_reload <= '0;
        end else begin
            if (wr_reg && off == OFF_TMR_CTRL)   tmr_en     <= mem_wdata[0];
            if (wr_reg && off == OFF_TMR_RELOAD) tmr_reload <= mem_wdata;
        end
    end

    dmr_timer #(
        .WIDTH (DATA_WIDTH)
    ) u_timer (
        .clk       (clk),
        .arst      (arst),
        .en        (tmr_en),
        .reload    (tmr_reload),
        .cnt       (tmr_cnt),
        .ovf_pulse (tmr_ovf)
    );
`else
    assign tmr_en     = 1'b0;
    assign tmr_reload = '0;
    assign tmr_cnt    = '0;
    assign tmr_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected values, a negedge monitor drains and compares.
// Timer scenarios are included when DMR_TIMER_EN is defined.
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_WE;
    logic [7:0] mem_rdata;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       irq;

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .MMIO_BASE  (8'hF8)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_WE    (mem_WE),
        .mem_rdata (mem_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    localparam int K_RDATA = 0;
    localparam int K_GPIO  = 1;
    localparam int K_IRQ   = 2;

    typedef struct {
        int         kind;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always @(negedge clk) begin : monitor
        chk_t       c;
        logic [7:0] act;
        while (q.size() > 0) begin
            c = q.pop_front();
            case (c.kind)
                K_RDATA: act = mem_rdata;
                K_GPIO:  act = gpio_out;
                default: act = {7'd0, irq};
            endcase
            n_total++;
            if (act === c.exp) n_pass++;
            else $display("FAIL %s: got %02h expected %02h", c.name, act, c.exp);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int kind, input logic [7:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        q.push_back(c);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
        mem_addr = addr;
        expect_sig(K_RDATA, exp, name);
        cyc();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        mem_addr  = addr;
        mem_wdata = data;
        mem_WE    = 1'b1;
        cyc();
        mem_WE    = 1'b0;
    endtask

    initial begin : stim
        arst      = 1'b1;
        mem_WE    = 1'b1;
        mem_addr  = 8'hF8;
        mem_wdata = 8'hAA;
        gpio_in   = 8'h00;
        repeat (3) cyc();
        n_total++;
        if (gpio_out === 8'h00) n_pass++;
        else $display("FAIL direct_rst_gpio_out: got %02h", gpio_out);
        n_total++;
        if (irq === 1'b0) n_pass++;
        else $display("FAIL direct_rst_irq: got %b", irq);
        arst   = 1'b0;
        mem_WE = 1'b0;
        expect_sig(K_GPIO, 8'h00, "rst_gpio_out");
        expect_sig(K_IRQ,  8'h00, "rst_irq");
        rd(8'hF8, 8'h00, "rst_we_ignored");
        rd(8'hFA, 8'h00, "rst_status");
        rd(8'hFB, 8'h00, "rst_irq_en");
        rd(8'hF9, 8'h00, "rst_gpio_in");

        wr(8'h20, 8'h11);
        rd(8'h20, 8'h11, "ram_20");
        wr(8'h10, 8'h33);
        mem_addr  = 8'h10;
        mem_wdata = 8'h5A;
        mem_WE    = 1'b1;
        expect_sig(K_RDATA, 8'h33, "ram_old_during_wr");
        cyc();
        mem_WE = 1'b0;
        rd(8'h10, 8'h5A, "ram_new_next_cyc");

        wr(8'hF8, 8'hC3);
        n_total++;
        if (gpio_out === 8'hC3) n_pass++;
        else $display("FAIL direct_gpio_out: got %02h expected c3", gpio_out);
        expect_sig(K_GPIO, 8'hC3, "gpio_out_after_edge");
        rd(8'hF8, 8'hC3, "gpio_out_rd");
        gpio_in = 8'h81;
        rd(8'hF9, 8'h00, "gpio_in_0cyc");
        rd(8'hF9, 8'h00, "gpio_in_1cyc");
        rd(8'hF9, 8'h81, "gpio_in_2cyc");

        wr(8'hFB, 8'h01);
        wr(8'hFD, 8'hFF);
        expect_sig(K_IRQ, 8'h00, "irq_lag");
        rd(8'hFA, 8'h01, "wr_fault_ro");
        expect_sig(K_IRQ, 8'h01, "irq_set");
        rd(8'hFD, 8'h00, "ro_unchanged");
        rd(8'h10, 8'h5A, "ram_unchanged");
        rd(8'hF8, 8'hC3, "gpio_unchanged");
        rd(8'hFB, 8'h01, "irq_en_rd");
        rd(8'hFF, 8'h00, "reserved_rd");

        wr(8'hFA, 8'h01);
        expect_sig(K_IRQ, 8'h01, "irq_hold");
        rd(8'hFA, 8'h00, "w1c_clear");
        expect_sig(K_IRQ, 8'h00, "irq_clear");
        wr(8'hFB, 8'hFF);
        rd(8'hFB, 8'h03, "irq_en_bits");

`ifdef DMR_TIMER_EN
        wr(8'hFE, 8'hFC);
        wr(8'hFC, 8'h01);
        rd(8'hFD, 8'h00, "tmr_start");
        repeat (253) cyc();
        rd(8'hFD, 8'hFE, "tmr_fe");
        mem_addr  = 8'hFA;
        mem_wdata = 8'h02;
        mem_WE    = 1'b1;
        expect_sig(K_RDATA, 8'h00, "sts_pre_ovf");
        cyc();
        mem_WE = 1'b0;
        expect_sig(K_IRQ, 8'h00, "irq_pre_ovf");
        rd(8'hFA, 8'h02, "ovf_set_wins");
        expect_sig(K_IRQ, 8'h01, "irq_ovf");
        rd(8'hFD, 8'hFD, "tmr_after_reload");
        wr(8'hFE, 8'h10);
        rd(8'hFD, 8'hFF, "reload_wr_no_effect");
        rd(8'hFD, 8'h10, "tmr_new_reload");
        wr(8'hFC, 8'h00);
        repeat (3) cyc();
        rd(8'hFD, 8'h12, "tmr_frozen");
        wr(8'hFC, 8'h01);
        rd(8'hFD, 8'h12, "tmr_resume_from");
        rd(8'hFD, 8'h13, "tmr_resumed");
        repeat (44) cyc();
        mem_addr = 8'hFD;
        expect_sig(K_RDATA, 8'h40, "tmr_40");
`else
        rd(8'hFC, 8'h00, "no_tmr_fc_rd");
        wr(8'hFC, 8'h01);
        rd(8'hFA, 8'h01, "no_tmr_fc_fault");
        wr(8'hFA, 8'h01);
        wr(8'hFE, 8'h12);
        rd(8'hFE, 8'h00, "no_tmr_fe_rd");
        rd(8'hFA, 8'h01, "no_tmr_fe_fault");
        mem_addr = 8'hFD;
        expect_sig(K_RDATA, 8'h00, "pre_rst_fd");
`endif
        expect_sig(K_IRQ, 8'h01, "pre_rst_irq");
        arst = 1'b1;
        cyc();
        mem_addr  = 8'h20;
        mem_wdata = 8'h22;
        mem_WE    = 1'b1;
        expect_sig(K_RDATA, 8'h11, "ram_rd_in_rst");
        cyc();
        arst   = 1'b0;
        mem_WE = 1'b0;
        expect_sig(K_IRQ, 8'h00, "rst2_irq");
        expect_sig(K_GPIO, 8'h00, "rst2_gpio_out");
        rd(8'h20, 8'h11, "rst2_we_ignored");
        rd(8'h10, 8'h5A, "rst2_ram_kept");
        rd(8'hFD, 8'h00, "rst2_cnt");
        rd(8'hFA, 8'h00, "rst2_status");
        rd(8'hFB, 8'h00, "rst2_irq_en");
        rd(8'hFC, 8'h00, "rst2_tmr_ctrl");
        rd(8'hFE, 8'h00, "rst2_reload");
        rd(8'hFD, 8'h00, "rst2_cnt_stopped");

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        if (n_pass == n_total && n_total >= 12) $display("PASS");
        else $display("FAIL summary: %0d of %0d passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, data-memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-003 SHALL have parameter MMIO_BASE, default 8'hF8, first memory-mapped I/O address; RAM occupies 0 to MMIO_BASE-1.
REQ-004 SHALL have port clk, input, 1, clock; reset arst, synchronous, active-high; clock clk.
REQ-005 SHALL have port arst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port mem_addr, input, ADDR_WIDTH, address driven by the CPU MAR.
REQ-007 SHALL have port mem_wdata, input, DATA_WIDTH, write data from the CPU MBR_o.
REQ-008 SHALL have port mem_WE, input, 1, write enable, one cycle per write.
REQ-009 SHALL have port mem_rdata, output, DATA_WIDTH, read data to the CPU mem_data_i.
REQ-010 SHALL have port gpio_in, input, DATA_WIDTH, asynchronous external inputs.
REQ-011 SHALL have port gpio_out, output, DATA_WIDTH, registered GPIO output.
REQ-012 SHALL have port irq, output, 1, high while any enabled sticky status bit is set.

Function
REQ-013 SHALL return mem_rdata combinationally from mem_addr in the same cycle, with no wait states, because the CPU samples it in the cycle after loading MAR.
REQ-014 SHALL commit a write on the rising clk edge where mem_WE=1; the new value SHALL be readable from the next cycle.
REQ-015 SHALL return the old data on a same-cycle read of an address being written.
REQ-016 Address map:
- 0x00 to MMIO_BASE-1: RAM.
- +0 GPIO_OUT: R/W.
- +1 GPIO_IN: R.
- +2 STATUS: R/W1C; bit0 wr_fault, bit1 tmr_ovf.
- +3 IRQ_EN: R/W, bits[1:0].
- +4 TMR_CTRL: R/W, bit0 enable.
- +5 TMR_CNT: R.
- +6 TMR_RELOAD: R/W.
- +7: reserved.
REQ-017 GPIO_IN SHALL read gpio_in through a two-flop synchronizer, giving 2-cycle latency.
REQ-018 A write to a read-only or reserved address SHALL leave all state unchanged and set STATUS.wr_fault.
REQ-019 Reserved addresses and unused register bits SHALL read 0.
REQ-020 A STATUS write SHALL clear each bit written 1; if a hardware set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-021 irq SHALL be registered and equal |(STATUS[1:0] & IRQ_EN[1:0]), one cycle after STATUS changes.
REQ-022 Timer, when TMR_CTRL.enable=1:
- TMR_CNT SHALL increment by 1 per clk.
- On the increment from 0xFF it SHALL load TMR_RELOAD and set tmr_ovf in the same cycle.
REQ-023 A write to TMR_RELOAD SHALL NOT affect TMR_CNT until the next overflow.
REQ-024 Setting enable 0 SHALL freeze TMR_CNT; setting it 1 again SHALL resume counting from the frozen value.

Reset
REQ-025 arst SHALL clear GPIO_OUT, the synchronizer, STATUS, IRQ_EN, TMR_CTRL, TMR_CNT, TMR_RELOAD and irq to 0.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 mem_WE=1 during arst SHALL be ignored.
REQ-028 arst asserted while the timer runs SHALL zero the count with no overflow flag.

Configuration
REQ-029 Macro DMR_TIMER_EN SHALL compile the timer in.
REQ-030 Without DMR_TIMER_EN:
- +4, +5 and +6 SHALL be reserved (read 0; writes set wr_fault).
- tmr_ovf SHALL be constant 0.
- No timer flops SHALL be synthesized.

Structure
REQ-031 Register offsets, STATUS bit indices and the DMR_TIMER_EN guard SHALL live in shared defines.v beside the opcode and flag defines.
REQ-032 The timer SHALL be sub-module dmr_timer (ports: clk, arst, en, reload, cnt, ovf_pulse).

Verification
REQ-033 Write 0x5A to 0x10, then read 0x10 -> 0x5A in the next cycle; a same-cycle read during the write returns the old value.
REQ-034 Write 0xC3 to 0xF8 -> gpio_out=0xC3 after the edge; gpio_in=0x81 -> 0xF9 reads 0x81 two cycles later.
REQ-035 Write 0xFF to 0xFD, IRQ_EN=0x01 -> STATUS=0x01 and irq=1 one cycle later; RAM and registers unchanged.
REQ-036 RELOAD=0xFC, CNT reaches 0xFF, enable=1 -> next cycle CNT=0xFC, STATUS[1]=1; W1C of bit1 on the overflow cycle leaves it 1.
REQ-037 arst mid-count at CNT=0x40 -> CNT=0, STATUS=0, irq=0; RAM 0x10 still reads 0x5A.
REQ-038 Build without DMR_TIMER_EN -> 0xFC reads 0; a write to 0xFC sets wr_fault.
